// File: rtl/bfp_pkg.sv
// Shared constants and helpers for the BFP decompression path.
package bfp_pkg;

    localparam int BFP_PAIRS_PER_RB = 6;
    localparam int BFP_SAMPLE_W     = 16;

    // Sign-extend the low w bits of m (w in 1..16) to a full 16-bit sample.
    function automatic logic [15:0] bfp_sign_extend(input logic [15:0] m, input logic [4:0] w);
        logic [4:0]         sh;
        logic signed [15:0] t;
        sh = 5'd16 - w;
        t  = signed'(m << sh);
        return t >>> sh;
    endfunction

    function automatic logic [15:0] bfp_sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/bfp_decomp_sample.sv
// Scales one sign-extended mantissa by its exponent and clamps or wraps to 16 bits.
module bfp_decomp_sample
    import bfp_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] mant,
    input  logic [3:0]  shift,
    output logic [15:0] sample
);

    logic signed [31:0] wide;
    logic [15:0]        sample_d;
    logic [15:0]        sample_q;

    always_comb begin
        wide     = signed'({{16{mant[15]}}, mant}) <<< shift;
        sample_d = sample_q;
        if (en) begin
            sample_d = SATURATE ? bfp_sat16(wide) : wide[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= '0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/bfp_decomp_expand.sv
// Final BFP decompression stage: tracks RB position, captures the exponent and
// expands two REs per word into 16-bit samples over a two-stage pipeline.
module bfp_decomp_expand
    import bfp_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  din_width,
    input  logic [63:0] din_data,
    input  logic        din_valid,
    input  logic        din_last,
    input  logic [31:0] din_user,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic [31:0] m_axis_tuser,
    output logic        err_exp_range,
    output logic        err_partial_rb
);

    localparam int                PIDX_W    = $clog2(BFP_PAIRS_PER_RB);
    localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(BFP_PAIRS_PER_RB - 1);
    localparam int                NS        = 4;

    logic [PIDX_W-1:0] pidx_q, pidx_d;
    logic [3:0]        exp_q, exp_d;

    logic              uncomp;
    logic [4:0]        w_eff;
    logic [5:0]        eidx;
    logic [5:0]        lo;
    logic [3:0]        e_raw, e_cur;
    logic [15:0]       mant_ext [NS];

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;
    logic [31:0]       s1_user_q, s1_user_d;
    logic [3:0]        s1_exp_q, s1_exp_d;
    logic              s1_err_exp_q, s1_err_exp_d;
    logic              s1_err_rb_q, s1_err_rb_d;
    logic [15:0]       s1_mant_q [NS];
    logic [15:0]       s1_mant_d [NS];

    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [31:0]       tuser_q, tuser_d;
    logic              err_exp_q, err_exp_d;
    logic              err_rb_q, err_rb_d;

    always_comb begin
        uncomp = (din_width == 4'd0);
        w_eff  = uncomp ? 5'd16 : {1'b0, din_width};
        eidx   = {din_width, 2'b00};
        e_raw  = din_data[eidx +: 4];
        // The exponent-bearing word uses its own exponent rather than the stale capture.
        e_cur  = uncomp ? 4'd0 : ((pidx_q == '0) ? e_raw : exp_q);

        lo = '0;
        for (int k = 0; k < NS; k++) begin
            lo          = 6'(w_eff) * 6'(NS - 1 - k);
            mant_ext[k] = bfp_sign_extend(din_data[lo +: 16], w_eff);
        end

        pidx_d = pidx_q;
        exp_d  = exp_q;
        if (din_valid) begin
            pidx_d = (din_last || pidx_q == PIDX_LAST) ? '0 : pidx_q + 1'b1;
            if (pidx_q == '0 && !uncomp) begin
                exp_d = e_raw;
            end
        end

        s1_valid_d   = din_valid;
        s1_last_d    = din_valid ? din_last : s1_last_q;
        s1_user_d    = din_valid ? din_user : s1_user_q;
        s1_exp_d     = din_valid ? e_cur : s1_exp_q;
        s1_err_exp_d = din_valid ? (!uncomp && ({1'b0, w_eff} + {2'b00, e_cur}) > 6'd16)
                                 : s1_err_exp_q;
        s1_err_rb_d  = din_valid ? (din_last && pidx_q != PIDX_LAST) : s1_err_rb_q;
        for (int k = 0; k < NS; k++) begin
            s1_mant_d[k] = din_valid ? mant_ext[k] : s1_mant_q[k];
        end

        tvalid_d  = s1_valid_q;
        tlast_d   = s1_valid_q & s1_last_q;
        err_exp_d = s1_valid_q & s1_err_exp_q;
        err_rb_d  = s1_valid_q & s1_err_rb_q;
        tuser_d   = s1_valid_q ? s1_user_q : tuser_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pidx_q       <= '0;
            exp_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_user_q    <= '0;
            s1_exp_q     <= '0;
            s1_err_exp_q <= 1'b0;
            s1_err_rb_q  <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                s1_mant_q[k] <= '0;
            end
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= '0;
            err_exp_q    <= 1'b0;
            err_rb_q     <= 1'b0;
        end else begin
            pidx_q       <= pidx_d;
            exp_q        <= exp_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_user_q    <= s1_user_d;
            s1_exp_q     <= s1_exp_d;
            s1_err_exp_q <= s1_err_exp_d;
            s1_err_rb_q  <= s1_err_rb_d;
            for (int k = 0; k < NS; k++) begin
                s1_mant_q[k] <= s1_mant_d[k];
            end
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            err_exp_q    <= err_exp_d;
            err_rb_q     <= err_rb_d;
        end
    end

    // Sample order on the output bus is I0, Q0, I1, Q1 from the LSB up.
    for (genvar gi = 0; gi < NS; gi++) begin : g_sample
        bfp_decomp_sample #(
            .SATURATE(SATURATE)
        ) u_sample (
            .clk   (clk),
            .rst   (rst),
            .en    (s1_valid_q),
            .mant  (s1_mant_q[gi]),
            .shift (s1_exp_q),
            .sample(m_axis_tdata[16*gi +: 16])
        );
    end

    assign m_axis_tvalid  = tvalid_q;
    assign m_axis_tlast   = tlast_q;
    assign m_axis_tuser   = tuser_q;
    assign err_exp_range  = err_exp_q;
    assign err_partial_rb = err_rb_q;

endmodule

// File: tb/tb_bfp_decomp_expand.sv
// Directed bench for bfp_decomp_expand with a saturating and a wrapping instance.
module tb_bfp_decomp_expand;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  din_width = '0;
    logic [63:0] din_data = '0;
    logic        din_valid = 1'b0;
    logic        din_last = 1'b0;
    logic [31:0] din_user = '0;

    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [31:0] m_axis_tuser;
    logic        err_exp_range;
    logic        err_partial_rb;

    logic [63:0] w_tdata;
    logic        w_tvalid;
    logic        w_tlast;
    logic [31:0] w_tuser;
    logic        w_err_exp;
    logic        w_err_rb;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] in_d [12];
    logic [63:0] ex_d [12];

    always #5 clk = ~clk;

    bfp_decomp_expand #(.SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .din_width(din_width), .din_data(din_data),
        .din_valid(din_valid), .din_last(din_last), .din_user(din_user),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .err_exp_range(err_exp_range), .err_partial_rb(err_partial_rb)
    );

    bfp_decomp_expand #(.SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .din_width(din_width), .din_data(din_data),
        .din_valid(din_valid), .din_last(din_last), .din_user(din_user),
        .m_axis_tdata(w_tdata), .m_axis_tvalid(w_tvalid),
        .m_axis_tlast(w_tlast), .m_axis_tuser(w_tuser),
        .err_exp_range(w_err_exp), .err_partial_rb(w_err_rb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [63:0] ed, input logic el,
                             input logic [31:0] eu, input logic ee, input logic ep);
        chk($sformatf("%s_tvalid", tag), 64'(m_axis_tvalid), 64'd1);
        chk($sformatf("%s_tdata", tag), m_axis_tdata, ed);
        chk($sformatf("%s_tlast", tag), 64'(m_axis_tlast), 64'(el));
        chk($sformatf("%s_tuser", tag), 64'(m_axis_tuser), 64'(eu));
        chk($sformatf("%s_err_exp", tag), 64'(err_exp_range), 64'(ee));
        chk($sformatf("%s_err_rb", tag), 64'(err_partial_rb), 64'(ep));
        $display("out %s tdata=%h tlast=%0b tuser=%h err_exp=%0b err_rb=%0b",
                 tag, m_axis_tdata, m_axis_tlast, m_axis_tuser, err_exp_range, err_partial_rb);
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic xfer(input logic v, input logic l, input logic [3:0] w,
                        input logic [63:0] d, input logic [31:0] u);
        din_valid = v;
        din_last  = l;
        din_width = w;
        din_data  = d;
        din_user  = u;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack(input int w, input logic [7:0] e,
                                         input logic [15:0] i0, input logic [15:0] q0,
                                         input logic [15:0] i1, input logic [15:0] q1);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << w) - 64'd1;
        r = 64'(e) << (4 * w);
        r = r | ((64'(i0) & m) << (3 * w));
        r = r | ((64'(q0) & m) << (2 * w));
        r = r | ((64'(i1) & m) << w);
        r = r | (64'(q1) & m);
        return r;
    endfunction

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
        chk("rst_err_exp", 64'(err_exp_range), 64'd0);
        chk("rst_err_rb", 64'(err_partial_rb), 64'd0);
        rst = 1'b0;
        xfer(1'b0, 1'b0, 4'd8, 64'd0, 32'd0);

        // Width 8, e = 2; later words carry garbage in the exponent slot
        in_d[0] = pack(8, 8'h02, 16'h81, 16'h7F, 16'h00, 16'h01);
        ex_d[0] = 64'h0004_0000_01FC_FE04;
        for (int k = 1; k < 6; k++) begin
            in_d[k] = pack(8, 8'h0F, 16'h7F, 16'h81, 16'h01, 16'hFF);
            ex_d[k] = 64'hFFFC_0004_FE04_01FC;
        end
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) xfer(1'b1, k == 5, 4'd8, in_d[k], 32'h100 + 32'(k));
            else       xfer(1'b0, 1'b0, 4'd8, 64'd0, 32'd0);
            if (k == 0) chk("t1_latency", 64'(m_axis_tvalid), 64'd0);
            else check_out($sformatf("t1_w%0d", k - 1), ex_d[k-1], k == 6,
                           32'h100 + 32'(k - 1), 1'b0, 1'b0);
        end

        // Uncompressed
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) xfer(1'b1, k == 5, 4'd0, 64'h1234_5678_9ABC_DEF0, 32'hA0 + 32'(k));
            else       xfer(1'b0, 1'b0, 4'd0, 64'd0, 32'd0);
            if (k > 0) check_out($sformatf("t2_w%0d", k - 1), 64'hDEF0_9ABC_5678_1234,
                                 k == 6, 32'hA0 + 32'(k - 1), 1'b0, 1'b0);
        end

        // Width 9, e = 9: overflow in both directions
        in_d[0] = pack(9, 8'h09, 16'h0FF, 16'h100, 16'h000, 16'h000);
        for (int k = 1; k < 6; k++) in_d[k] = pack(9, 8'h00, 16'h0FF, 16'h100, 16'h000, 16'h000);
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) xfer(1'b1, k == 5, 4'd9, in_d[k], 32'hB0 + 32'(k));
            else       xfer(1'b0, 1'b0, 4'd9, 64'd0, 32'd0);
            if (k > 0) begin
                check_out($sformatf("t3_w%0d", k - 1), 64'h0000_0000_8000_7FFF,
                          k == 6, 32'hB0 + 32'(k - 1), 1'b1, 1'b0);
                chk($sformatf("t3_wrap_w%0d_tvalid", k - 1), 64'(w_tvalid), 64'd1);
                chk($sformatf("t3_wrap_w%0d_tdata", k - 1), w_tdata, 64'h0000_0000_0000_FE00);
            end
        end

        // Two RBs at width 4 with an idle cycle after every word
        for (int k = 0; k < 12; k++) begin
            in_d[k] = pack(4, (k == 0) ? 8'h01 : ((k == 6) ? 8'h03 : 8'h0F),
                           16'h7, 16'h8, 16'h1, 16'hF);
            ex_d[k] = (k < 6) ? 64'hFFFE_0002_FFF0_000E : 64'hFFF8_0008_FFC0_0038;
        end
        for (int k = 0; k < 12; k++) begin
            xfer(1'b1, k == 11, 4'd4, in_d[k], 32'h200 + 32'(k));
            if (k == 1) chk("t4_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
            xfer(1'b0, 1'b0, 4'd4, 64'd0, 32'd0);
            check_out($sformatf("t4_w%0d", k), ex_d[k], k == 11, 32'h200 + 32'(k), 1'b0, 1'b0);
        end

        // Short packet ending at word 3, then a fresh exponent-bearing word
        for (int k = 0; k < 4; k++) begin
            in_d[k] = pack(8, (k == 0) ? 8'h01 : 8'h0F, 16'h01, 16'h01, 16'h01, 16'h01);
            ex_d[k] = 64'h0002_0002_0002_0002;
        end
        in_d[4] = pack(8, 8'h04, 16'h10, 16'h00, 16'h00, 16'h00);
        ex_d[4] = 64'h0000_0000_0000_0100;
        for (int k = 0; k <= 5; k++) begin
            if (k < 5) xfer(1'b1, k == 3, 4'd8, in_d[k], 32'h300 + 32'(k));
            else       xfer(1'b0, 1'b0, 4'd8, 64'd0, 32'd0);
            if (k > 0) check_out($sformatf("t5_w%0d", k - 1), ex_d[k-1], k == 4,
                                 32'h300 + 32'(k - 1), 1'b0, k == 4);
        end

        // Reset while word 2 is presented
        xfer(1'b1, 1'b0, 4'd8, pack(8, 8'h02, 16'h05, 16'h05, 16'h05, 16'h05), 32'h3F0);
        xfer(1'b1, 1'b0, 4'd8, pack(8, 8'h0F, 16'h05, 16'h05, 16'h05, 16'h05), 32'h3F1);
        rst = 1'b1;
        xfer(1'b1, 1'b0, 4'd8, pack(8, 8'h0F, 16'h05, 16'h05, 16'h05, 16'h05), 32'h3F2);
        chk("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6_rst_tdata", m_axis_tdata, 64'd0);
        rst = 1'b0;
        xfer(1'b0, 1'b0, 4'd8, 64'd0, 32'd0);
        chk("t6_inflight_tvalid", 64'(m_axis_tvalid), 64'd0);
        xfer(1'b1, 1'b0, 4'd8, pack(8, 8'h03, 16'h01, 16'h00, 16'h00, 16'h00), 32'h400);
        xfer(1'b0, 1'b0, 4'd8, 64'd0, 32'd0);
        check_out("t6_first", 64'h0000_0000_0000_0008, 1'b0, 32'h400, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
